// File: rtl/seed_collect.sv
`default_nettype none
// ============================================================================
// Module      : seed_collect
// Description : Raster-tracks the compare-stage pixel stream and writes the
//               linear address of every border-safe keypoint into seed RAM.
// Revision    : 1.0  initial release
// ============================================================================
module seed_collect #(
    parameter int WIDE       = 256,
    parameter int HIGN       = 256,
    parameter int CNT_DW     = 16,
    parameter int BORDER     = 8,
    parameter int SEED_DEPTH = 511
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic              is_extrema,
    input  logic              desc_busy,
    output logic              wr_en_seed,
    output logic [8:0]        wr_addr_seed,
    output logic [CNT_DW-1:0] wr_data_seed,
    output logic [8:0]        cnt_seed,
    output logic              cpr_end,
    output logic              frame_empty,
    output logic              overflow,
    output logic              err_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [15:0] X_LO     = 16'(BORDER);
    localparam logic [15:0] X_HI     = 16'(WIDE - 1 - BORDER);
    localparam logic [15:0] Y_LO     = 16'(BORDER);
    localparam logic [15:0] Y_HI     = 16'(HIGN - 1 - BORDER);
    localparam logic [15:0] X_LAST   = 16'(WIDE - 1);
    localparam logic [15:0] Y_LAST   = 16'(HIGN - 1);
    localparam logic [8:0]  CNT_FULL = 9'(SEED_DEPTH);
    localparam logic [47:0] WIDE_W   = 48'(WIDE);

    state_t            state;
    state_t            state_nx;
    logic [15:0]       x;
    logic [15:0]       y;
    logic              hold_first;

    logic              restart;
    logic              take;
    logic              in_window;
    logic              accept;
    logic              last_pix;
    logic [15:0]       cur_x;
    logic [15:0]       cur_y;
    logic [8:0]        cnt_base;
    logic [47:0]       lin_full;
    logic [CNT_DW-1:0] lin_data;

    // A frame_start restarts the frame at this very pixel, so the pixel in
    // flight is evaluated against the restarted position and count.
    always_comb begin
        restart   = frame_start && ((state == IDLE) || (state == COLLECT));
        take      = pix_valid && (restart || (state == COLLECT));
        cur_x     = restart ? 16'd0 : x;
        cur_y     = restart ? 16'd0 : y;
        cnt_base  = restart ? 9'd0 : cnt_seed;
        in_window = (cur_x >= X_LO) && (cur_x <= X_HI) &&
                    (cur_y >= Y_LO) && (cur_y <= Y_HI);
        accept    = take && is_extrema && in_window;
        last_pix  = (cur_x == X_LAST) && (cur_y == Y_LAST);
        lin_full  = ({32'd0, cur_y} * WIDE_W) + {32'd0, cur_x};
        lin_data  = CNT_DW'(lin_full);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (restart) begin
                    state_nx = (take && last_pix) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (take && last_pix) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = (cnt_seed != 9'd0) ? HOLD : IDLE;
            end
            HOLD: begin
                // Reader busy trails cpr_end by one cycle, so the first HOLD
                // cycle cannot trust a low desc_busy.
                if (!hold_first && !desc_busy) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x            <= 16'd0;
            y            <= 16'd0;
            hold_first   <= 1'b0;
            wr_en_seed   <= 1'b0;
            wr_addr_seed <= 9'd0;
            wr_data_seed <= '0;
            cnt_seed     <= 9'd0;
            cpr_end      <= 1'b0;
            frame_empty  <= 1'b0;
            overflow     <= 1'b0;
            err_busy     <= 1'b0;
        end else begin
            wr_en_seed  <= 1'b0;
            cpr_end     <= 1'b0;
            frame_empty <= 1'b0;
            err_busy    <= 1'b0;
            hold_first  <= (state == DONE);

            if (restart) begin
                cnt_seed <= 9'd0;
                overflow <= 1'b0;
                x        <= 16'd0;
                y        <= 16'd0;
            end

            if (take) begin
                if (cur_x == X_LAST) begin
                    x <= 16'd0;
                    y <= cur_y + 16'd1;
                end else begin
                    x <= cur_x + 16'd1;
                end
            end

            if (accept) begin
                if (cnt_base == CNT_FULL) begin
                    overflow <= 1'b1;
                end else begin
                    wr_en_seed   <= 1'b1;
                    wr_addr_seed <= cnt_base;
                    wr_data_seed <= lin_data;
                    cnt_seed     <= cnt_base + 9'd1;
                end
            end

            if (state == DONE) begin
                cpr_end     <= (cnt_seed != 9'd0);
                frame_empty <= (cnt_seed == 9'd0);
            end

            if ((state == HOLD) && frame_start) begin
                err_busy <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
